packet_tx: RTL and testbench
============================

Name: packet_tx

Overview:
Outgoing-packet encoder and transmitter for the EER-RL cluster node, the send-side counterpart of the receive-side controller that decodes fPacketType and related fields.
- On a request from node logic, latches the packet fields and waits for a clear channel.
- DATA packets additionally wait for the node's timeslot grant.
- Emits the packet as a sequence of WORD_WIDTH words to the radio under a valid/ready handshake.

Parameters:
WORD_WIDTH, 16, packet word width
CCA_CYCLES, 3, consecutive channel_clear cycles required before sending
BACKOFF_CYCLES, 8, wait length after a failed clear-channel assessment
MAX_RETRIES, 3, failed assessments allowed before abort

Ports:
clk  in  1  clock
nrst  in  1  reset; synchronous, active-high (nrst=1 resets on the rising clk edge)
tx_req  in  1  start request; sampled only in IDLE
tx_type  in  3  000 HB, 001 CHE, 010 INV, 011 MR, 100 CHT, 101 DATA, 110 SOS, 111 invalid
myNodeID  in  WORD_WIDTH  source ID
destinationID  in  WORD_WIDTH  destination for CHT and DATA
hopsFromCH  in  WORD_WIDTH  hop count field
chosenCH  in  WORD_WIDTH  chosen CH for MR (also used as MR destination)
timeslot  in  WORD_WIDTH  assigned slot for CHT
energy  in  WORD_WIDTH  residual energy
payload  in  WORD_WIDTH  DATA payload
channel_clear  in  1  carrier-sense idle
okToSend  in  1  timeslot grant from controller
tx_ready  in  1  radio accepts word
tx_word  out  WORD_WIDTH  outgoing word
tx_valid  out  1  tx_word valid
tx_last  out  1  final word of packet
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse on successful completion
tx_fail  out  1  one-cycle pulse on abort or invalid type

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- Word 0 (header) is {type[2:0], 5'b0, len[7:0]}, where len is the total word count. Word 1 is myNodeID. Word 2 is the destination. BCAST = 16'hFFFF.
- Packet layouts:
  - HB: hdr, src, BCAST, hops, energy (len 5)
  - CHE: hdr, src, BCAST, energy (4)
  - INV: hdr, src, BCAST, hops (4)
  - MR: hdr, src, chosenCH, energy (4)
  - CHT: hdr, src, destinationID, timeslot (4)
  - DATA: hdr, src, destinationID, hops, payload (5)
  - SOS: hdr, src, BCAST, energy (4)
- IDLE:
  - tx_req=1 with type 111: tx_fail pulses the next cycle; FSM stays in IDLE.
  - tx_req=1 with a valid type: all fields are latched that cycle and the FSM moves to WAIT_SLOT for DATA, otherwise to CCA.
  - Input changes after the latch are ignored.
- WAIT_SLOT: holds until okToSend=1, then moves to CCA.
- CCA:
  - Counts consecutive channel_clear=1 cycles. Reaching CCA_CYCLES moves to SEND.
  - Any channel_clear=0 clears the count and increments retry.
  - If retry reaches MAX_RETRIES, go to FAIL; otherwise go to BACKOFF.
- BACKOFF: counts BACKOFF_CYCLES cycles, then returns to CCA with the count cleared. channel_clear is ignored here.
- SEND:
  - tx_valid=1 and tx_word = current word.
  - The index advances only on tx_valid & tx_ready.
  - tx_word holds stable while tx_ready=0.
  - tx_last=1 on word len-1.
  - The handshake on the last word moves to DONE.
  - No stall timeout.
- DONE: tx_done=1 for one cycle, then IDLE. FAIL: tx_fail=1 for one cycle, then IDLE. Both clear retry and the index.
- tx_req while tx_busy is ignored (no queueing).
- nrst mid-packet: the next cycle returns to IDLE with all outputs 0. No tx_done or tx_fail pulse.
- Latency: a valid non-DATA request with channel continuously clear gives the first tx_valid exactly CCA_CYCLES+1 cycles after the tx_req cycle.

Decomposition:
- Shared package (e.g. the protocol package):
  - Packet-type enum (PKT_HB … PKT_INVALID)
  - BCAST constant
  - Header field positions
  - Per-type length function
  - FSM state enum
- One natural sub-module, pkt_word_mux: combinational selection of tx_word from latched fields, type and word index. The FSM and counters stay in packet_tx.

Test Plan:
1. HB, myNodeID=12, hops=1, energy=0x0004, channel_clear and tx_ready held 1 -> words 0x0005, 0x000C, 0xFFFF, 0x0001, 0x0004. tx_last on the 5th word; tx_done one cycle later; first tx_valid 4 cycles after tx_req.
2. MR, chosenCH=23, energy=0x0004, tx_ready toggling 1/0 -> 0x6004, 0x000C, 0x0017, 0x0004. Each word is held while ready=0; no word skipped or repeated.
3. DATA, dest=3, okToSend=0 for 10 cycles then 1 -> no tx_valid before grant + CCA_CYCLES. Words 0xA005, 0x000C, 0x0003, hops, payload.
4. CHE, channel_clear 1,1,0 then 1 -> one BACKOFF of 8 cycles, then a fresh 3-cycle CCA, then 4 words sent. Channel never clear -> tx_fail after 3 failed assessments; tx_valid never asserted.
5. tx_type=111 -> tx_fail pulse, tx_busy stays 0. A second tx_req during SEND is ignored. nrst=1 during word 2 -> all outputs 0 the next cycle, then a fresh HB completes normally.

Source files
------------

// File: rtl/packet_tx_pkg.sv
// Shared protocol definitions for the EER-RL cluster-node packet transmitter.
package packet_tx_pkg;

    localparam int unsigned PKT_TYPE_W = 3;
    localparam int unsigned HDR_LEN_W  = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned STATE_W    = 3;

    localparam logic [15:0] PKT_BCAST = 16'hFFFF;

    typedef enum logic [PKT_TYPE_W-1:0] {
        PKT_HB      = 3'd0,
        PKT_CHE     = 3'd1,
        PKT_INV     = 3'd2,
        PKT_MR      = 3'd3,
        PKT_CHT     = 3'd4,
        PKT_DATA    = 3'd5,
        PKT_SOS     = 3'd6,
        PKT_INVALID = 3'd7
    } pkt_type_e;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_SLOT = 3'd1;
    localparam logic [STATE_W-1:0] ST_CCA       = 3'd2;
    localparam logic [STATE_W-1:0] ST_BACKOFF   = 3'd3;
    localparam logic [STATE_W-1:0] ST_SEND      = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd5;
    localparam logic [STATE_W-1:0] ST_FAIL      = 3'd6;

    // Total word count of a packet, header included.
    function automatic logic [HDR_LEN_W-1:0] pkt_len(input pkt_type_e t);
        case (t)
            PKT_HB, PKT_DATA: pkt_len = 8'd5;
            PKT_INVALID:      pkt_len = 8'd0;
            default:          pkt_len = 8'd4;
        endcase
    endfunction

endpackage

// File: rtl/pkt_word_mux.sv
// Selects the outgoing word from the latched packet fields, type and word index.
module pkt_word_mux
    import packet_tx_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16
) (
    input  pkt_type_e             type_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [WORD_WIDTH-1:0] src_i,
    input  logic [WORD_WIDTH-1:0] dest_i,
    input  logic [WORD_WIDTH-1:0] hops_i,
    input  logic [WORD_WIDTH-1:0] chosen_ch_i,
    input  logic [WORD_WIDTH-1:0] timeslot_i,
    input  logic [WORD_WIDTH-1:0] energy_i,
    input  logic [WORD_WIDTH-1:0] payload_i,
    output logic [WORD_WIDTH-1:0] word_c_o
);

    logic [WORD_WIDTH-1:0] hdr_c;
    logic [WORD_WIDTH-1:0] dest_c;
    logic [WORD_WIDTH-1:0] w3_c;
    logic [WORD_WIDTH-1:0] w4_c;

    // Header: type in the top bits, word count in the low byte.
    always_comb begin
        hdr_c = '0;
        hdr_c[WORD_WIDTH-1 -: PKT_TYPE_W] = type_i;
        hdr_c[HDR_LEN_W-1:0] = pkt_len(type_i);
    end

    // Per-type field placement for words 2..4.
    always_comb begin
        dest_c = WORD_WIDTH'(PKT_BCAST);
        w3_c   = energy_i;
        w4_c   = energy_i;
        case (type_i)
            PKT_MR:   dest_c = chosen_ch_i;
            PKT_CHT:  begin dest_c = dest_i; w3_c = timeslot_i; end
            PKT_DATA: begin dest_c = dest_i; w3_c = hops_i; w4_c = payload_i; end
            PKT_HB,
            PKT_INV:  w3_c = hops_i;
            default:  ;
        endcase
    end

    // Word select by index.
    always_comb begin
        word_c_o = '0;
        case (idx_i)
            3'd0:    word_c_o = hdr_c;
            3'd1:    word_c_o = src_i;
            3'd2:    word_c_o = dest_c;
            3'd3:    word_c_o = w3_c;
            3'd4:    word_c_o = w4_c;
            default: word_c_o = '0;
        endcase
    end

endmodule

// File: rtl/packet_tx.sv
// Packet encoder/transmitter: latch request, wait slot/clear channel, stream words.
module packet_tx
    import packet_tx_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 16,
    parameter int unsigned CCA_CYCLES     = 3,
    parameter int unsigned BACKOFF_CYCLES = 8,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  tx_req,
    input  logic [2:0]            tx_type,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] timeslot,
    input  logic [WORD_WIDTH-1:0] energy,
    input  logic [WORD_WIDTH-1:0] payload,
    input  logic                  channel_clear,
    input  logic                  okToSend,
    input  logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] tx_word,
    output logic                  tx_valid,
    output logic                  tx_last,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_fail
);

    localparam int unsigned CNT_MAX = (CCA_CYCLES > BACKOFF_CYCLES) ? CCA_CYCLES : BACKOFF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    pkt_type_e             type_q;
    logic [WORD_WIDTH-1:0] src_q, dest_q, hops_q, chosen_q, slot_q, energy_q, payload_q;

    logic [WORD_WIDTH-1:0] tx_word_q;
    logic                  tx_valid_q, tx_last_q, tx_busy_q, tx_done_q, tx_fail_q;

    logic                  latch_c;
    logic                  inv_fail_c;
    logic                  hs_c;
    logic [IDX_W-1:0]      last_idx_c;
    logic [WORD_WIDTH-1:0] word_c;

    assign hs_c       = (state_q == ST_SEND) && tx_valid_q && tx_ready;
    assign last_idx_c = IDX_W'(pkt_len(type_q) - 8'd1);

    // Word lookup for the index that will be presented next cycle.
    pkt_word_mux #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_word_mux (
        .type_i      (type_q),
        .idx_i       (idx_d),
        .src_i       (src_q),
        .dest_i      (dest_q),
        .hops_i      (hops_q),
        .chosen_ch_i (chosen_q),
        .timeslot_i  (slot_q),
        .energy_i    (energy_q),
        .payload_i   (payload_q),
        .word_c_o    (word_c)
    );

    // Next-state, counter and index logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        idx_d      = idx_q;
        latch_c    = 1'b0;
        inv_fail_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_req) begin
                    if (tx_type == PKT_INVALID) begin
                        inv_fail_c = 1'b1;
                    end else begin
                        latch_c = 1'b1;
                        cnt_d   = '0;
                        state_d = (tx_type == PKT_DATA) ? ST_WAIT_SLOT : ST_CCA;
                    end
                end
            end
            ST_WAIT_SLOT: begin
                if (okToSend) state_d = ST_CCA;
            end
            ST_CCA: begin
                if (channel_clear) begin
                    if (cnt_q == CNT_W'(CCA_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SEND;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_q == RETRY_W'(MAX_RETRIES - 1)) ? ST_FAIL : ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                if (cnt_q == CNT_W'(BACKOFF_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CCA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (hs_c) begin
                    if (idx_q == last_idx_c) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE, ST_FAIL: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                retry_d = '0;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            idx_q   <= idx_d;
        end
    end

    // Packet fields captured on an accepted request; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (nrst) begin
            type_q    <= PKT_HB;
            src_q     <= '0;
            dest_q    <= '0;
            hops_q    <= '0;
            chosen_q  <= '0;
            slot_q    <= '0;
            energy_q  <= '0;
            payload_q <= '0;
        end else if (latch_c) begin
            type_q    <= pkt_type_e'(tx_type);
            src_q     <= myNodeID;
            dest_q    <= destinationID;
            hops_q    <= hopsFromCH;
            chosen_q  <= chosenCH;
            slot_q    <= timeslot;
            energy_q  <= energy;
            payload_q <= payload;
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (nrst) begin
            tx_word_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_fail_q  <= 1'b0;
        end else begin
            tx_word_q  <= (state_d == ST_SEND) ? word_c : '0;
            tx_valid_q <= (state_d == ST_SEND);
            tx_last_q  <= (state_d == ST_SEND) && (idx_d == last_idx_c);
            tx_busy_q  <= (state_d != ST_IDLE);
            tx_done_q  <= (state_d == ST_DONE);
            tx_fail_q  <= (state_d == ST_FAIL) || inv_fail_c;
        end
    end

    assign tx_word  = tx_word_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;
    assign tx_fail  = tx_fail_q;

endmodule

// File: tb/tb_packet_tx.sv
// Bench for packet_tx: directed scenarios plus randomized packets against a reference model.
module tb_packet_tx;

    localparam int unsigned W    = 16;
    localparam int          CCA  = 3;
    localparam int          BO   = 8;
    localparam int          MAXR = 3;

    logic         clk = 1'b0;
    logic         nrst;
    logic         tx_req;
    logic [2:0]   tx_type;
    logic [W-1:0] myNodeID, destinationID, hopsFromCH, chosenCH, timeslot, energy, payload;
    logic         channel_clear, okToSend, tx_ready;
    logic [W-1:0] tx_word;
    logic         tx_valid, tx_last, tx_busy, tx_done, tx_fail;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    bit          clr_at [0:1023];

    always #5 clk = ~clk;

    packet_tx #(
        .WORD_WIDTH     (W),
        .CCA_CYCLES     (CCA),
        .BACKOFF_CYCLES (BO),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .tx_req        (tx_req),
        .tx_type       (tx_type),
        .myNodeID      (myNodeID),
        .destinationID (destinationID),
        .hopsFromCH    (hopsFromCH),
        .chosenCH      (chosenCH),
        .timeslot      (timeslot),
        .energy        (energy),
        .payload       (payload),
        .channel_clear (channel_clear),
        .okToSend      (okToSend),
        .tx_ready      (tx_ready),
        .tx_word       (tx_word),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_fail       (tx_fail)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected word list from the packet layout table.
    function automatic void build_words(input int typ, input logic [15:0] src, dst, hops, ch, slot, en, pay);
        int len;
        exp_q.delete();
        if (typ == 7) return;
        len = (typ == 0 || typ == 5) ? 5 : 4;
        exp_q.push_back(16'(typ * 8192 + len));
        exp_q.push_back(src);
        case (typ)
            0: begin exp_q.push_back(16'hFFFF); exp_q.push_back(hops); exp_q.push_back(en); end
            1: begin exp_q.push_back(16'hFFFF); exp_q.push_back(en); end
            2: begin exp_q.push_back(16'hFFFF); exp_q.push_back(hops); end
            3: begin exp_q.push_back(ch); exp_q.push_back(en); end
            4: begin exp_q.push_back(dst); exp_q.push_back(slot); end
            5: begin exp_q.push_back(dst); exp_q.push_back(hops); exp_q.push_back(pay); end
            default: begin exp_q.push_back(16'hFFFF); exp_q.push_back(en); end
        endcase
    endfunction

    // Cycle of first word given the channel history, or -1 with the abort cycle.
    function automatic int predict(input int cca_start, output int fail_cyc);
        int pos = cca_start;
        fail_cyc = -1;
        for (int attempt = 0; attempt < MAXR; attempt++) begin
            int k = 0;
            while (k < CCA && clr_at[pos + k]) k++;
            if (k == CCA) return pos + CCA;
            if (attempt == MAXR - 1) begin
                fail_cyc = pos + k + 1;
                return -1;
            end
            pos = pos + k + 1 + BO;
        end
        return -1;
    endfunction

    task automatic scramble_inputs();
        tx_type       = 3'($urandom_range(0, 6));
        myNodeID      = 16'($urandom);
        destinationID = 16'($urandom);
        hopsFromCH    = 16'($urandom);
        chosenCH      = 16'($urandom);
        timeslot      = 16'($urandom);
        energy        = 16'($urandom);
        payload       = 16'($urandom);
    endtask

    // One request from IDLE through done/fail; called right after a sample point.
    task automatic run_pkt(input int typ, input int grant, input int rdy_mode, input int clr_mode,
                           input bit req_in_send,
                           input logic [15:0] src, dst, hops, ch, slot, en, pay);
        int s, f, cs, ev, first_v, last_hs, n_valid, n_done, n_fail, done_cyc, fail_cyc, busy_cnt;
        bit prev_v, prev_r;
        logic [15:0] prev_w;
        logic [15:0] got_q[$];
        for (int i = 0; i < 1024; i++) begin
            case (clr_mode)
                0:       clr_at[i] = 1'b1;
                1:       clr_at[i] = (i > 40) ? 1'b1 : ($urandom_range(0, 4) != 0);
                2:       clr_at[i] = 1'b0;
                default: clr_at[i] = (i != 3);
            endcase
        end
        build_words(typ, src, dst, hops, ch, slot, en, pay);
        f = -1;
        if (typ == 7) begin
            s = -1;
            f = 1;
        end else begin
            cs = (typ == 5) ? grant + 1 : 1;
            s  = predict(cs, f);
        end
        ev = -1; first_v = -1; last_hs = -1; n_valid = 0; n_done = 0; n_fail = 0;
        done_cyc = -1; fail_cyc = -1; busy_cnt = 0; prev_v = 0; prev_r = 0; prev_w = '0;

        tx_req = 1'b1; tx_type = 3'(typ);
        myNodeID = src; destinationID = dst; hopsFromCH = hops; chosenCH = ch;
        timeslot = slot; energy = en; payload = pay;
        okToSend = 1'b0; channel_clear = clr_at[0]; tx_ready = 1'b0;

        for (int j = 1; j <= 600; j++) begin
            @(posedge clk); #1;
            if (prev_v && !prev_r) begin
                chk("hold_word", 32'(tx_word), 32'(prev_w));
                chk("hold_valid", 32'(tx_valid), 32'd1);
            end
            if (tx_valid) begin
                n_valid++;
                if (first_v < 0) first_v = j;
            end
            if (tx_busy) busy_cnt++;
            if (tx_done) begin n_done++; done_cyc = j; if (ev < 0) ev = j; end
            if (tx_fail) begin n_fail++; fail_cyc = j; if (ev < 0) ev = j; end
            if (ev >= 0 && j == ev + 2) break;

            tx_req = req_in_send && tx_valid && (j == first_v);
            scramble_inputs();
            okToSend      = (j >= grant);
            channel_clear = clr_at[j];
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (j % 2 == 1);
                default: tx_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_word);
                last_hs = j;
                chk("last_flag", 32'(tx_last), 32'(got_q.size() == exp_q.size()));
            end
            prev_v = tx_valid; prev_r = tx_ready; prev_w = tx_word;
        end
        tx_req = 1'b0;

        if (ev < 0) chk("timeout", 32'd0, 32'd1);
        if (s >= 0) begin
            chk("first_valid_cycle", 32'(first_v), 32'(s));
            chk("word_count", 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                chk($sformatf("word%0d_type%0d", i, typ), 32'(got_q[i]), 32'(exp_q[i]));
            chk("done_pulses", 32'(n_done), 32'd1);
            chk("done_cycle", 32'(done_cyc), 32'(last_hs + 1));
            chk("fail_pulses", 32'(n_fail), 32'd0);
            chk("busy_cycles", 32'(busy_cnt), 32'(done_cyc));
        end else begin
            chk("valid_cycles", 32'(n_valid), 32'd0);
            chk("fail_pulses", 32'(n_fail), 32'd1);
            chk("fail_cycle", 32'(fail_cyc), 32'(f));
            chk("done_pulses", 32'(n_done), 32'd0);
            chk("busy_cycles", 32'(busy_cnt), (typ == 7) ? 32'd0 : 32'(f));
        end
    endtask

    initial begin
        nrst = 1'b1; tx_req = 1'b0; tx_type = '0;
        myNodeID = '0; destinationID = '0; hopsFromCH = '0; chosenCH = '0;
        timeslot = '0; energy = '0; payload = '0;
        channel_clear = 1'b0; okToSend = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_word", 32'(tx_word), 32'd0);
        chk("rst_last", 32'(tx_last), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_fail", 32'(tx_fail), 32'd0);
        nrst = 1'b0;
        @(posedge clk); #1;

        // HB, clear channel, ready always high
        run_pkt(0, 0, 0, 0, 0, 16'd12, 16'd0, 16'd1, 16'd0, 16'd0, 16'h0004, 16'd0);
        // MR with toggling ready
        run_pkt(3, 0, 1, 0, 0, 16'd12, 16'd0, 16'd0, 16'd23, 16'd0, 16'h0004, 16'd0);
        // DATA with grant after 10 cycles
        run_pkt(5, 11, 0, 0, 0, 16'd12, 16'd3, 16'd2, 16'd0, 16'd0, 16'd0, 16'hBEEF);
        // CHE with one failed assessment, then never-clear channel
        run_pkt(1, 0, 0, 3, 0, 16'd12, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0004, 16'd0);
        run_pkt(1, 0, 0, 2, 0, 16'd12, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0004, 16'd0);
        // invalid type, then a second request during SEND
        run_pkt(7, 0, 0, 0, 0, 16'd12, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        run_pkt(0, 0, 2, 0, 1, 16'd12, 16'd0, 16'd1, 16'd0, 16'd0, 16'h0004, 16'd0);

        // reset while word 2 is on the bus
        tx_req = 1'b1; tx_type = 3'd0; myNodeID = 16'd12; hopsFromCH = 16'd1; energy = 16'h0004;
        channel_clear = 1'b1; tx_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            tx_req = 1'b0;
            if (j == 6) begin
                chk("pre_rst_word2", 32'(tx_word), 32'h0000FFFF);
                nrst = 1'b1;
            end
            if (j == 7) begin
                chk("mid_rst_valid", 32'(tx_valid), 32'd0);
                chk("mid_rst_word", 32'(tx_word), 32'd0);
                chk("mid_rst_last", 32'(tx_last), 32'd0);
                chk("mid_rst_busy", 32'(tx_busy), 32'd0);
                chk("mid_rst_done", 32'(tx_done), 32'd0);
                chk("mid_rst_fail", 32'(tx_fail), 32'd0);
                nrst = 1'b0;
            end
            if (j == 8) chk("post_rst_busy", 32'(tx_busy), 32'd0);
        end
        run_pkt(0, 0, 0, 0, 0, 16'd12, 16'd0, 16'd1, 16'd0, 16'd0, 16'h0004, 16'd0);

        // randomized packets
        for (int n = 0; n < 40; n++) begin
            int r, typ, cm;
            r   = $urandom_range(0, 15);
            typ = (r < 14) ? (r % 7) : 7;
            r   = $urandom_range(0, 9);
            cm  = (r < 5) ? 1 : ((r < 8) ? 0 : 2);
            run_pkt(typ, $urandom_range(1, 12), $urandom_range(0, 2), cm, 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
